// File: rtl/data_memory.sv
// -----------------------------------------------------------------------------
// data_memory
//
// Backing main memory for the data cache. It holds DEPTH lines of DATA_WIDTH
// bits and is addressed by byte address at 32-byte line granularity. Every
// access is a fixed-latency transaction that ends with a one-cycle ack.
//
// Handshake: the requester raises enable_i and holds addr_i, data_i and
// write_i stable until ack_o. The request is accepted at the first rising
// edge in IDLE with enable_i=1. ack_o is high for exactly one cycle, LATENCY
// cycles after the accepting edge (the ack cycle included). A write commits
// at the rising edge that ends the ack cycle. At least one IDLE cycle
// separates consecutive transactions.
//
// Ports:
//   clk_i     in   1           clock, rising edge
//   rst_i     in   1           synchronous active-high reset (memory kept)
//   addr_i    in   32          byte address; line index = addr_i[13:5]
//   data_i    in   DATA_WIDTH  write line data
//   enable_i  in   1           request valid
//   write_i   in   1           1 = write line, 0 = read line
//   ack_o     out  1           transaction complete (one cycle)
//   data_o    out  DATA_WIDTH  line currently addressed (valid during ack)
// -----------------------------------------------------------------------------
module data_memory #(
    parameter int LATENCY    = 10,
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [31:0]           addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  enable_i,
    input  logic                  write_i,
    output logic                  ack_o,
    output logic [DATA_WIDTH-1:0] data_o
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_we;
    logic [IDX_W-1:0] line_idx;

    // Not cleared by reset: contents preloaded before reset must survive.
    reg [DATA_WIDTH-1:0] memory [0:DEPTH-1];

    // Byte offset and bits above the array are ignored, so addresses alias
    // modulo the array size.
    assign line_idx = addr_i[5 +: IDX_W];

    logic unused_addr;
    assign unused_addr = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_o   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    // Ack cycle: the transaction retires at the coming edge,
                    // regardless of enable_i (no abort once accepted).
                    ack_o   = 1'b1;
                    mem_we  = write_i;
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Reset at the ack edge aborts the write as well.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) begin
            memory[line_idx] <= data_i;
        end
    end

    // Read is asynchronous; during a write's ack cycle it still shows the
    // old line because the write lands at the end of that cycle.
    assign data_o = memory[line_idx];

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;

    logic         clk_i;
    logic         rst_i;
    logic [31:0]  addr_i;
    logic [255:0] data_i;
    logic         enable_i;
    logic         write_i;
    logic         ack_o;
    logic [255:0] data_o;

    data_memory dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_i   (addr_i),
        .data_i   (data_i),
        .enable_i (enable_i),
        .write_i  (write_i),
        .ack_o    (ack_o),
        .data_o   (data_o)
    );

    // ---------------- clock / cycle counter ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    typedef struct {
        int           exp_cyc;
        logic         chk_data;
        logic [255:0] exp_data;
        string        name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per ack and checks timing and read data.
    logic prev_ack = 1'b0;
    always @(negedge clk_i) begin
        exp_t e;
        if (ack_o) begin
            check("ack_one_cycle", {255'd0, prev_ack}, 256'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 256'd1, 256'd0);
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_ack_cycle"}, 256'(cyc), 256'(e.exp_cyc));
                if (e.chk_data) check({e.name, "_data"}, data_o, e.exp_data);
            end
        end
        prev_ack = ack_o;
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge while the block is idle (or about to be, for a
    // held back-to-back request). Accepting edge is the next posedge, so the
    // ack is seen at the negedge where cyc == now + LATENCY.
    task automatic issue(input logic [31:0] addr, input logic [255:0] data, input logic wr,
                         input logic chk, input logic [255:0] exp_data, input string name);
        exp_t e;
        addr_i   = addr;
        data_i   = data;
        write_i  = wr;
        enable_i = 1'b1;
        e.exp_cyc  = cyc + 10;
        e.chk_data = chk;
        e.exp_data = exp_data;
        e.name     = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input string name, input logic drop);
        int n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!ack_o && n < 40);
        if (!ack_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s_timeout: no ack within 40 cycles, expected one", name);
            exp_q.delete();
        end
        if (drop) enable_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_i    = 1'b1;
        enable_i = 1'b0;
        write_i  = 1'b0;
        addr_i   = '0;
        data_i   = '0;
        dut.memory[0] = 256'h5;
        dut.memory[2] = 256'hAA;

        // Reset for two cycles; contents must survive.
        repeat (2) begin
            @(negedge clk_i);
            check("ack_in_reset", {255'd0, ack_o}, 256'd0);
        end
        rst_i = 1'b0;
        repeat (2) begin
            @(negedge clk_i);
            check("ack_idle", {255'd0, ack_o}, 256'd0);
        end
        check("mem0_after_reset", dut.memory[0], 256'h5);

        // Plain read of the preloaded line.
        issue(32'h0000, '0, 1'b0, 1'b1, 256'h5, "rd_0000");
        wait_ack("rd_0000", 1'b1);
        @(negedge clk_i);

        // Write, then read back through a different byte of the same line.
        issue(32'h0400, 256'hDEADBEEF, 1'b1, 1'b0, '0, "wr_0400");
        wait_ack("wr_0400", 1'b1);
        @(negedge clk_i);
        check("mem32_after_wr", dut.memory[32], 256'hDEADBEEF);
        issue(32'h0410, '0, 1'b0, 1'b1, 256'hDEADBEEF, "rd_0410");
        wait_ack("rd_0410", 1'b1);
        @(negedge clk_i);

        // Back-to-back: enable held through the write ack, read follows
        // straight after the mandatory IDLE cycle (11 cycles after ack).
        issue(32'h0020, 256'h1234_5678_9ABC, 1'b1, 1'b0, '0, "b2b_wr");
        wait_ack("b2b_wr", 1'b0);
        @(negedge clk_i);
        check("mem1_after_b2b_wr", dut.memory[1], 256'h1234_5678_9ABC);
        issue(32'h0020, '0, 1'b0, 1'b1, 256'h1234_5678_9ABC, "b2b_rd");
        wait_ack("b2b_rd", 1'b1);
        @(negedge clk_i);

        // Reset in the middle of a write: no ack, no write.
        addr_i   = 32'h0040;
        data_i   = 256'h1;
        write_i  = 1'b1;
        enable_i = 1'b1;
        repeat (5) @(negedge clk_i);
        rst_i    = 1'b1;
        enable_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (12) begin
            @(negedge clk_i);
            check("no_ack_after_abort", {255'd0, ack_o}, 256'd0);
        end
        check("mem2_after_abort", dut.memory[2], 256'hAA);
        issue(32'h0040, '0, 1'b0, 1'b1, 256'hAA, "rd_after_rst");
        wait_ack("rd_after_rst", 1'b1);
        @(negedge clk_i);

        // Aliasing: 0x4020 maps to line 1; write ack shows the old contents.
        issue(32'h4020, 256'h7, 1'b1, 1'b1, 256'h1234_5678_9ABC, "alias_wr");
        wait_ack("alias_wr", 1'b1);
        @(negedge clk_i);
        check("mem1_after_alias", dut.memory[1], 256'h7);
        issue(32'h0020, '0, 1'b0, 1'b1, 256'h7, "alias_rd");
        wait_ack("alias_rd", 1'b1);
        repeat (3) @(negedge clk_i);

        check("queue_empty", 256'(exp_q.size()), 256'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
